pc_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the 16-bit pipelined CPU.
- Owns the architectural PC register and drives the instruction-memory/I-cache request handshake (stall-capable, multi-cycle on miss).
- Loads the IF/ID register and applies hazard-unit stalls, branch redirects from PC_control (resolved in ID) and HLT halting.

---
 rtl/pc_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the I-mem request and loads IF/ID.
// Latency: with zero-wait memory, first IF/ID valid 2 cycles after reset release, then 1 instr/cycle.
// Backpressure: stall holds IF/ID and PC; a stalled return is parked in hold_buf with the request dropped.
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted
);

    typedef enum logic [2:0] {IDLE, FETCH, DROP, HOLD, HALT} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] tgt_buf;
    logic [15:0] hold_buf;

    logic [15:0] rpc;
    logic [15:0] pc_next;
    logic [15:0] accept_dat;
    logic        do_accept;

    assign rpc        = redirect_pc & 16'hFFFE;
    assign pc_next    = pc + 16'd2;
    assign accept_dat = (state == HOLD) ? hold_buf : imem_data;
    assign do_accept  = !redirect && !stall &&
                        ((state == FETCH && imem_ready) || state == HOLD);

    // DROP keeps the abandoned address on the bus until memory completes it.
    assign imem_req  = (state == FETCH) || (state == DROP);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            tgt_buf     <= 16'h0000;
            hold_buf    <= 16'h0000;
            if_valid    <= 1'b0;
            if_instr    <= 16'h0000;
            if_pc       <= 16'h0000;
            if_pc_plus2 <= 16'h0000;
            halted      <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        if (imem_ready) begin
                            pc <= rpc;
                        end else begin
                            tgt_buf <= rpc;
                            state   <= DROP;
                        end
                    end else if (imem_ready && stall) begin
                        hold_buf <= imem_data;
                        state    <= HOLD;
                    end else if (!imem_ready && !stall) begin
                        if_valid <= 1'b0;
                    end
                end
                DROP: begin
                    if_valid <= 1'b0;
                    if (imem_ready) begin
                        pc    <= redirect ? rpc : tgt_buf;
                        state <= FETCH;
                    end else if (redirect) begin
                        tgt_buf <= rpc;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc       <= rpc;
                        if_valid <= 1'b0;
                        state    <= FETCH;
                    end
                end
                HALT: begin
                    if (redirect) begin
                        halted   <= 1'b0;
                        pc       <= rpc;
                        if_valid <= 1'b0;
                        state    <= FETCH;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Shared accept path for a fresh return (FETCH) or a parked one (HOLD).
            if (do_accept) begin
                if_instr    <= accept_dat;
                if_pc       <= pc;
                if_pc_plus2 <= pc_next;
                if_valid    <= 1'b1;
                pc          <= pc_next;
                if (accept_dat[15:12] == HLT_OPCODE) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    state <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a transaction-level reference model and literal pins.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, imem_ready;
    logic [15:0] redirect_pc, imem_data;
    logic        imem_req, if_valid, halted;
    logic [15:0] imem_addr, if_instr, if_pc, if_pc_plus2;

    logic        s2_stall, s2_redirect, s2_ready;
    logic [15:0] s2_rpc, s2_data;
    logic        d2_req, d2_valid, d2_halted;
    logic [15:0] d2_addr, d2_instr, d2_pc, d2_pc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2), .halted(halted)
    );

    pc_fetch_ctrl #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(s2_stall), .redirect(s2_redirect),
        .redirect_pc(s2_rpc), .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_ready(s2_ready), .imem_data(s2_data), .if_valid(d2_valid),
        .if_instr(d2_instr), .if_pc(d2_pc), .if_pc_plus2(d2_pc2), .halted(d2_halted)
    );

    // Reference model: a started flag, the PC, and three "why are we not fetching" conditions.
    logic        m_started, m_drop, m_parked, m_stopped;
    logic [15:0] m_pc, m_tgt, m_park;
    logic        m_valid;
    logic [15:0] m_instr, m_ipc, m_ipc2;

    function automatic logic [15:0] mem(input logic [15:0] a);
        if (a == 16'h000A || a == 16'h0402) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    task automatic model_reset();
        m_started = 0; m_drop = 0; m_parked = 0; m_stopped = 0;
        m_pc = 16'h0000; m_tgt = 0; m_park = 0;
        m_valid = 0; m_instr = 0; m_ipc = 0; m_ipc2 = 0;
    endtask

    task automatic model_take(input logic [15:0] d);
        m_instr = d; m_ipc = m_pc; m_ipc2 = m_pc + 16'd2; m_valid = 1;
        m_pc = m_pc + 16'd2;
        if (d[15:12] == 4'hF) m_stopped = 1;
    endtask

    task automatic model_step();
        logic [15:0] t;
        t = {redirect_pc[15:1], 1'b0};
        if (!m_started) begin
            m_started = 1;
        end else if (m_stopped) begin
            if (redirect) begin m_stopped = 0; m_pc = t; m_valid = 0; end
            else if (!stall) m_valid = 0;
        end else if (m_parked) begin
            if (redirect) begin m_parked = 0; m_pc = t; m_valid = 0; end
            else if (!stall) begin m_parked = 0; model_take(m_park); end
        end else if (m_drop) begin
            m_valid = 0;
            if (imem_ready) begin m_pc = redirect ? t : m_tgt; m_drop = 0; end
            else if (redirect) m_tgt = t;
        end else if (redirect) begin
            m_valid = 0;
            if (imem_ready) m_pc = t;
            else begin m_drop = 1; m_tgt = t; end
        end else if (imem_ready) begin
            if (stall) begin m_parked = 1; m_park = imem_data; end
            else model_take(imem_data);
        end else if (!stall) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = rst_n && m_started && !m_parked && !m_stopped;
        chk("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {15'd0, if_valid}, {15'd0, m_valid});
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_ipc);
        chk("if_pc_plus2", if_pc_plus2, m_ipc2);
        chk("halted", {15'd0, halted}, {15'd0, m_stopped});
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare on the falling edge.
    task automatic cyc(input logic s, input logic r, input logic [15:0] rp, input logic rd);
        stall = s; redirect = r; redirect_pc = rp; imem_ready = rd;
        imem_data = mem(imem_addr);
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 1; imem_data = 0;
        s2_stall = 0; s2_redirect = 0; s2_rpc = 0; s2_ready = 1; s2_data = 16'h1000;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_req_lit", {15'd0, imem_req}, 16'd0);
        rst_n = 1;

        // zero-wait fetch of 0x0000 and 0x0002
        cyc(0, 0, 0, 1);
        chk("dead_cycle_valid", {15'd0, if_valid}, 16'd0);
        chk("d2_first_addr", d2_addr, 16'hFFFE);
        chk("d2_first_req", {15'd0, d2_req}, 16'd1);
        cyc(0, 0, 0, 1);
        chk("first_valid_lit", {15'd0, if_valid}, 16'd1);
        chk("first_pc_lit", if_pc, 16'h0000);
        chk("d2_pc_fffe", d2_pc, 16'hFFFE);
        chk("d2_plus2_wrap", d2_pc2, 16'h0000);
        chk("d2_addr_wrap", d2_addr, 16'h0000);
        cyc(0, 0, 0, 1);
        chk("second_plus2_lit", if_pc_plus2, 16'h0004);
        chk("d2_pc_0000", d2_pc, 16'h0000);

        // three-cycle miss on 0x0004
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("miss_addr_lit", imem_addr, 16'h0004);
        end
        cyc(0, 0, 0, 1);
        chk("miss_done_pc_lit", if_pc, 16'h0004);
        chk("miss_next_addr_lit", imem_addr, 16'h0006);

        // redirect while 0x0006 pending, re-redirect inside DROP
        cyc(0, 1, 16'h0100, 0);
        chk("drop_addr_held_lit", imem_addr, 16'h0006);
        cyc(0, 1, 16'h0200, 0);
        cyc(0, 0, 0, 1);
        chk("drop_target_lit", imem_addr, 16'h0200);
        chk("drop_no_valid_lit", {15'd0, if_valid}, 16'd0);

        // redirect coinciding with ready, then stalled return -> HOLD
        cyc(0, 1, 16'h0008, 1);
        cyc(1, 0, 0, 1);
        chk("hold_req_lit", {15'd0, imem_req}, 16'd0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("hold_release_pc_lit", if_pc, 16'h0008);
        chk("hold_next_addr_lit", imem_addr, 16'h000A);

        // HLT at 0x000A, then wrong-path recovery with odd target
        cyc(0, 0, 0, 1);
        chk("hlt_halted_lit", {15'd0, halted}, 16'd1);
        chk("hlt_instr_lit", if_instr, 16'hF000);
        cyc(0, 0, 0, 0);
        chk("hlt_once_lit", {15'd0, if_valid}, 16'd0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 16'h0021, 0);
        chk("unhalt_addr_lit", imem_addr, 16'h0020);
        cyc(0, 0, 0, 1);

        // redirect beats stall while parked in HOLD
        cyc(1, 0, 0, 1);
        cyc(1, 1, 16'h0040, 0);
        chk("hold_redirect_valid_lit", {15'd0, if_valid}, 16'd0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("stall_miss_hold_lit", {15'd0, if_valid}, 16'd1);

        // asynchronous reset in the middle of a miss
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("async_rst_req_lit", {15'd0, imem_req}, 16'd0);
        chk("async_rst_valid_lit", {15'd0, if_valid}, 16'd0);
        compare_all();
        @(negedge clk);
        rst_n = 1;

        // stale ready in IDLE, then redirect+ready in DROP, then redirect beats HLT
        cyc(0, 0, 0, 1);
        chk("idle_stale_ready_lit", {15'd0, if_valid}, 16'd0);
        cyc(0, 1, 16'h0300, 0);
        cyc(0, 1, 16'h0400, 1);
        chk("drop_same_cycle_lit", imem_addr, 16'h0400);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 16'h0010, 1);
        chk("redirect_over_hlt_lit", {15'd0, halted}, 16'd0);
        cyc(0, 0, 0, 1);
        chk("final_pc_lit", if_pc, 16'h0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
